branch_resolve_unit: RTL and testbench

Execute-stage consumer of the 2RI16/I26 branch decode bundle (BEQ, BNE, BLT, BGE, BLTU, BGEU, B, BL, JIRL). It evaluates branch conditions and targets from register operands, compares the result against the front-end prediction, and produces a single-cycle redirect on mispredict. It also produces the link write-back for BL and JIRL. It is a 2-stage valid/ready pipeline: an operand-capture stage S1 and a resolve/output stage S2, with flush and self-squash.

---
 rtl/branch_resolve_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolver: S1 captures the decode bundle, S2 holds the resolved result and redirect.
// Optional statistics counters are built only when BRANCH_STAT_EN is defined.
`ifndef ALU_SEL_JUMP_BRANCH
`define ALU_SEL_JUMP_BRANCH 3'b101
`endif
`ifndef JIRL_OPCODE
`define JIRL_OPCODE 6'b010011
`endif
`ifndef B_OPCODE
`define B_OPCODE 6'b010100
`endif
`ifndef BL_OPCODE
`define BL_OPCODE 6'b010101
`endif
`ifndef BEQ_OPCODE
`define BEQ_OPCODE 6'b010110
`endif
`ifndef BNE_OPCODE
`define BNE_OPCODE 6'b010111
`endif
`ifndef BLT_OPCODE
`define BLT_OPCODE 6'b011000
`endif
`ifndef BGE_OPCODE
`define BGE_OPCODE 6'b011001
`endif
`ifndef BLTU_OPCODE
`define BLTU_OPCODE 6'b011010
`endif
`ifndef BGEU_OPCODE
`define BGEU_OPCODE 6'b011011
`endif

module branch_resolve_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_data_i,
  input  logic [31:0] reg2_data_i,
  input  logic [4:0]  reg_write_addr_i,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_target_i,
  input  logic        flush_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] pc_o,
  output logic        taken_o,
  output logic        wb_en_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] br_total_o,
  output logic [31:0] br_miss_o
);

  logic        s1_v_r, s1_pred_taken_r;
  logic [31:0] s1_pc_r, s1_inst_r, s1_reg1_r, s1_reg2_r, s1_pred_target_r;
  logic [2:0]  s1_sel_r;
  logic [4:0]  s1_waddr_r;

  logic        s2_v_r, s2_taken_r, s2_wb_en_r, s2_miss_r;
  logic [31:0] s2_pc_r, s2_wb_data_r, s2_redirect_pc_r;
  logic [4:0]  s2_wb_addr_r;

  logic        s2_free_s, s2_fire_s, squash_s, accept_s, s2_load_s;
  logic [5:0]  op_s;
  logic [31:0] off16_s, off26_s, link_pc_s, target_s, redirect_pc_s;
  logic        eq_s, lt_s, ltu_s, is_br_s, taken_s, wb_en_s, miss_s;
  logic [4:0]  wb_addr_s;
  logic [31:0] wb_data_s;

  assign ready_o   = !s1_v_r || !s2_v_r || ready_i;
  assign s2_free_s = !s2_v_r || ready_i;
  assign s2_fire_s = s2_v_r && ready_i;
  // A mispredict leaving S2 makes everything younger (S1 and this cycle's input) wrong-path.
  assign squash_s  = s2_fire_s && s2_miss_r;
  assign accept_s  = valid_i && ready_o;
  assign s2_load_s = !flush_i && s2_free_s && s1_v_r && !squash_s;

  assign op_s      = s1_inst_r[31:26];
  assign off16_s   = {{14{s1_inst_r[25]}}, s1_inst_r[25:10], 2'b00};
  assign off26_s   = {{4{s1_inst_r[9]}}, s1_inst_r[9:0], s1_inst_r[25:10], 2'b00};
  assign link_pc_s = s1_pc_r + 32'd4;
  assign eq_s      = (s1_reg1_r == s1_reg2_r);
  assign lt_s      = ($signed(s1_reg1_r) < $signed(s1_reg2_r));
  assign ltu_s     = (s1_reg1_r < s1_reg2_r);

  // Resolve direction, target and link write-back of the bundle held in S1.
  always_comb begin
    is_br_s   = 1'b0;
    taken_s   = 1'b0;
    target_s  = s1_pc_r + off16_s;
    wb_en_s   = 1'b0;
    wb_addr_s = 5'd0;
    wb_data_s = 32'd0;
    if (s1_sel_r == `ALU_SEL_JUMP_BRANCH) begin
      is_br_s = 1'b1;
      case (op_s)
        `BEQ_OPCODE:  taken_s = eq_s;
        `BNE_OPCODE:  taken_s = !eq_s;
        `BLT_OPCODE:  taken_s = lt_s;
        `BGE_OPCODE:  taken_s = !lt_s;
        `BLTU_OPCODE: taken_s = ltu_s;
        `BGEU_OPCODE: taken_s = !ltu_s;
        `B_OPCODE: begin
          taken_s  = 1'b1;
          target_s = s1_pc_r + off26_s;
        end
        `BL_OPCODE: begin
          taken_s   = 1'b1;
          target_s  = s1_pc_r + off26_s;
          wb_en_s   = 1'b1;
          wb_addr_s = 5'd1;
          wb_data_s = link_pc_s;
        end
        `JIRL_OPCODE: begin
          taken_s   = 1'b1;
          target_s  = s1_reg1_r + off16_s;
          wb_en_s   = (s1_waddr_r != 5'd0);
          wb_addr_s = s1_waddr_r;
          wb_data_s = link_pc_s;
        end
        default: is_br_s = 1'b0;
      endcase
    end else begin
      is_br_s = 1'b0;
    end
  end

  assign miss_s        = is_br_s && ((taken_s != s1_pred_taken_r) ||
                                     (taken_s && (target_s != s1_pred_target_r)));
  assign redirect_pc_s = taken_s ? target_s : link_pc_s;

  // S1 operand capture stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_r           <= 1'b0;
      s1_pc_r          <= 32'd0;
      s1_inst_r        <= 32'd0;
      s1_sel_r         <= 3'd0;
      s1_reg1_r        <= 32'd0;
      s1_reg2_r        <= 32'd0;
      s1_waddr_r       <= 5'd0;
      s1_pred_taken_r  <= 1'b0;
      s1_pred_target_r <= 32'd0;
    end else if (flush_i || squash_s) begin
      s1_v_r <= 1'b0;
    end else if (accept_s) begin
      s1_v_r           <= 1'b1;
      s1_pc_r          <= pc_i;
      s1_inst_r        <= inst_i;
      s1_sel_r         <= alusel_i;
      s1_reg1_r        <= reg1_data_i;
      s1_reg2_r        <= reg2_data_i;
      s1_waddr_r       <= reg_write_addr_i;
      s1_pred_taken_r  <= pred_taken_i;
      s1_pred_target_r <= pred_target_i;
    end else if (s2_free_s) begin
      s1_v_r <= 1'b0;
    end
  end

  // S2 resolved-result stage; payload only changes when a live bundle moves in.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v_r           <= 1'b0;
      s2_pc_r          <= 32'd0;
      s2_taken_r       <= 1'b0;
      s2_wb_en_r       <= 1'b0;
      s2_wb_addr_r     <= 5'd0;
      s2_wb_data_r     <= 32'd0;
      s2_miss_r        <= 1'b0;
      s2_redirect_pc_r <= 32'd0;
    end else if (flush_i) begin
      s2_v_r <= 1'b0;
    end else if (s2_free_s) begin
      s2_v_r <= s2_load_s;
      if (s2_load_s) begin
        s2_pc_r          <= s1_pc_r;
        s2_taken_r       <= taken_s;
        s2_wb_en_r       <= wb_en_s;
        s2_wb_addr_r     <= wb_addr_s;
        s2_wb_data_r     <= wb_data_s;
        s2_miss_r        <= miss_s;
        s2_redirect_pc_r <= redirect_pc_s;
      end
    end
  end

  assign valid_o       = s2_v_r;
  assign pc_o          = s2_pc_r;
  assign taken_o       = s2_taken_r;
  assign wb_en_o       = s2_wb_en_r;
  assign wb_addr_o     = s2_wb_addr_r;
  assign wb_data_o     = s2_wb_data_r;
  assign redirect_o    = s2_v_r && s2_miss_r && ready_i && !flush_i && !rst;
  assign redirect_pc_o = redirect_o ? s2_redirect_pc_r : 32'd0;

`ifdef BRANCH_STAT_EN
  logic        s2_is_br_r;
  logic [31:0] br_total_r, br_miss_r;

  // Branch-class tag travelling alongside the S2 payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_is_br_r <= 1'b0;
    end else if (s2_load_s) begin
      s2_is_br_r <= is_br_s;
    end
  end

  // Saturating statistics; flush never clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_total_r <= 32'd0;
      br_miss_r  <= 32'd0;
    end else begin
      if (s2_fire_s && s2_is_br_r && !flush_i && (br_total_r != 32'hFFFF_FFFF))
        br_total_r <= br_total_r + 32'd1;
      if (redirect_o && (br_miss_r != 32'hFFFF_FFFF))
        br_miss_r <= br_miss_r + 32'd1;
    end
  end

  assign br_total_o = br_total_r;
  assign br_miss_o  = br_miss_r;
`else
  assign br_total_o = 32'd0;
  assign br_miss_o  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expectations are queued at accept and checked at S2 handshake.
module tb_branch_resolve_unit;

  localparam logic [2:0] SEL_JB  = 3'b101;
  localparam logic [2:0] SEL_ALU = 3'b001;
  localparam logic [5:0] OP_JIRL = 6'h13, OP_B = 6'h14, OP_BL = 6'h15, OP_BEQ = 6'h16,
                         OP_BNE = 6'h17, OP_BLT = 6'h18, OP_BGE = 6'h19, OP_BLTU = 6'h1a,
                         OP_BGEU = 6'h1b;

  logic clk, rst, valid_i, ready_o, pred_taken_i, flush_i, valid_o, ready_i;
  logic taken_o, wb_en_o, redirect_o;
  logic [31:0] pc_i, inst_i, reg1_data_i, reg2_data_i, pred_target_i;
  logic [31:0] pc_o, wb_data_o, redirect_pc_o, br_total_o, br_miss_o;
  logic [2:0] alusel_i;
  logic [4:0] reg_write_addr_i, wb_addr_o;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i), .inst_i(inst_i),
    .alusel_i(alusel_i), .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .reg_write_addr_i(reg_write_addr_i), .pred_taken_i(pred_taken_i),
    .pred_target_i(pred_target_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .pc_o(pc_o), .taken_o(taken_o), .wb_en_o(wb_en_o), .wb_addr_o(wb_addr_o),
    .wb_data_o(wb_data_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .br_total_o(br_total_o), .br_miss_o(br_miss_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_def;
    logic        miss;
    logic [31:0] rpc;
    logic        is_br;
    logic        chk_lat;
    logic [31:0] acc_cyc;
  } exp_t;

  exp_t        q[$];
  int          n_vec, n_err;
  logic [31:0] cyc, exp_total, exp_miss;
  bit          took, prev_stall, cur_lat, rnd_ready;
  logic [71:0] prev_snap;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] snap();
    return {valid_o, pc_o, taken_o, wb_en_o, wb_addr_o, wb_data_o};
  endfunction

  // Reference behaviour computed from the raw bundle fields.
  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] inst,
                                 input logic [2:0] sel, input logic [31:0] r1,
                                 input logic [31:0] r2, input logic [4:0] wa,
                                 input logic pt, input logic [31:0] ptg);
    exp_t e;
    logic [15:0] f16;
    logic [25:0] f26;
    logic [5:0] op;
    logic [31:0] tgt;
    int o16, o26;
    bit br, tk;
    e = '0;
    op = inst[31:26];
    f16 = inst[25:10];
    f26 = {inst[9:0], inst[25:10]};
    o16 = int'($signed(f16)) * 4;
    o26 = int'($signed(f26)) * 4;
    tgt = pc + 32'(o16);
    br = (sel == SEL_JB);
    tk = 1'b0;
    case (op)
      OP_BEQ:  tk = (r1 == r2);
      OP_BNE:  tk = (r1 != r2);
      OP_BLT:  tk = ($signed(r1) < $signed(r2));
      OP_BGE:  tk = ($signed(r1) >= $signed(r2));
      OP_BLTU: tk = (r1 < r2);
      OP_BGEU: tk = (r1 >= r2);
      OP_B, OP_BL: begin tk = 1'b1; tgt = pc + 32'(o26); end
      OP_JIRL: begin tk = 1'b1; tgt = r1 + 32'(o16); end
      default: br = 1'b0;
    endcase
    if (!br) tk = 1'b0;
    e.pc = pc;
    e.taken = tk;
    e.is_br = br;
    if (br && op == OP_BL) begin
      e.wb_en = 1'b1; e.wb_addr = 5'd1; e.wb_data = pc + 32'd4; e.wb_def = 1'b1;
    end
    if (br && op == OP_JIRL) begin
      e.wb_en = (wa != 5'd0); e.wb_addr = wa; e.wb_data = pc + 32'd4; e.wb_def = 1'b1;
    end
    e.miss = br && ((tk != pt) || (tk && tgt != ptg));
    e.rpc = tk ? tgt : pc + 32'd4;
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    bit hs, sq;
    sq = 1'b0;
    @(negedge clk);
    if (rst) begin
      q.delete();
      exp_total = '0;
      exp_miss = '0;
      prev_stall = 1'b0;
      took = 1'b0;
    end else begin
      check("br_total", br_total_o, exp_total);
      check("br_miss", br_miss_o, exp_miss);
      if (prev_stall) check("hold", snap(), prev_snap);
      hs = valid_o && ready_i && !flush_i;
      if (flush_i) begin
        check("flush_redirect", redirect_o, 1'b0);
        q.delete();
      end else if (hs) begin
        if (q.size() == 0) begin
          check("spurious_valid", valid_o, 1'b0);
        end else begin
          e = q.pop_front();
          check("pc", pc_o, e.pc);
          check("taken", taken_o, e.taken);
          check("wb_en", wb_en_o, e.wb_en);
          if (e.wb_def) begin
            check("wb_addr", wb_addr_o, e.wb_addr);
            check("wb_data", wb_data_o, e.wb_data);
          end
          check("redirect", redirect_o, e.miss);
          check("redirect_pc", redirect_pc_o, e.miss ? e.rpc : 32'd0);
          if (e.chk_lat) check("latency", cyc - e.acc_cyc, 32'd2);
          if (e.miss) begin
            q.delete();
            sq = 1'b1;
          end
`ifdef BRANCH_STAT_EN
          if (e.is_br) exp_total++;
          if (e.miss) exp_miss++;
`endif
        end
      end else begin
        check("no_redirect", redirect_o, 1'b0);
        check("no_redirect_pc", redirect_pc_o, 32'd0);
      end
      took = valid_i && ready_o;
      if (took && !flush_i && !sq) begin
        e = model(pc_i, inst_i, alusel_i, reg1_data_i, reg2_data_i, reg_write_addr_i,
                  pred_taken_i, pred_target_i);
        e.chk_lat = cur_lat;
        e.acc_cyc = cyc;
        q.push_back(e);
      end
      prev_stall = valid_o && !ready_i && !flush_i;
      prev_snap = snap();
    end
    @(posedge clk);
    cyc++;
    #1;
    if (rnd_ready) ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] inst, input logic [2:0] sel,
                      input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] wa,
                      input logic pt, input logic [31:0] ptg, input bit lat);
    pc_i = pc; inst_i = inst; alusel_i = sel; reg1_data_i = r1; reg2_data_i = r2;
    reg_write_addr_i = wa; pred_taken_i = pt; pred_target_i = ptg; cur_lat = lat;
    valid_i = 1'b1;
    took = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (took) break;
    end
    if (!took) check("send_timeout", 1'b0, 1'b1);
    valid_i = 1'b0;
  endtask

  function automatic logic [31:0] i16(input logic [5:0] op, input logic [15:0] f,
                                      input logic [4:0] rj, input logic [4:0] rd);
    return {op, f, rj, rd};
  endfunction

  function automatic logic [31:0] i26(input logic [5:0] op, input logic [25:0] f);
    return {op, f[15:0], f[25:16]};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] vals [4];
    logic [5:0] ops [9];
    logic [15:0] f;
    logic [31:0] pc, r1;
    vals = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000};
    ops = '{OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_B, OP_BL, OP_JIRL};
    n_vec = 0; n_err = 0; cyc = '0; exp_total = '0; exp_miss = '0;
    prev_stall = 1'b0; rnd_ready = 1'b0; cur_lat = 1'b0; took = 1'b0; prev_snap = '0;
    rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    pc_i = '0; inst_i = '0; alusel_i = '0; reg1_data_i = '0; reg2_data_i = '0;
    reg_write_addr_i = '0; pred_taken_i = 1'b0; pred_target_i = '0;

    @(posedge clk); #1;
    @(negedge clk);
    check("rst_valid", valid_o, 1'b0);
    check("rst_ready", ready_o, 1'b1);
    check("rst_outs", {pc_o, taken_o, wb_en_o, wb_addr_o, wb_data_o}, 72'd0);
    check("rst_redirect", {redirect_o, redirect_pc_o}, 72'd0);
    check("rst_counters", {br_total_o, br_miss_o}, 72'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // BEQ taken and correctly predicted, latency 2
    send(32'h1C00_0000, i16(OP_BEQ, 16'd4, 5'd4, 5'd5), SEL_JB, 32'd5, 32'd5, 5'd0,
         1'b1, 32'h1C00_0010, 1'b1);
    idle(3);
    // BLT signed taken, BLTU unsigned not taken (mispredicted) back-to-back
    send(32'h200, i16(OP_BLT, 16'd8, 5'd1, 5'd2), SEL_JB, 32'hFFFF_FFFF, 32'd1, 5'd0,
         1'b1, 32'h220, 1'b1);
    send(32'h204, i16(OP_BLTU, 16'd8, 5'd1, 5'd2), SEL_JB, 32'hFFFF_FFFF, 32'd1, 5'd0,
         1'b1, 32'h224, 1'b1);
    idle(3);
    // BL link, then BL predicted not taken
    send(32'h100, i26(OP_BL, 26'h3FF_FFFF), SEL_JB, 32'd0, 32'd0, 5'd7, 1'b1, 32'hFC, 1'b1);
    send(32'h100, i26(OP_BL, 26'h3FF_FFFF), SEL_JB, 32'd0, 32'd0, 5'd7, 1'b0, 32'h0, 1'b1);
    idle(3);
    // JIRL to r0 and to r5
    send(32'h300, i16(OP_JIRL, 16'd1, 5'd4, 5'd0), SEL_JB, 32'h2000, 32'd0, 5'd0,
         1'b1, 32'h2000, 1'b1);
    send(32'h300, i16(OP_JIRL, 16'd1, 5'd4, 5'd5), SEL_JB, 32'h2000, 32'd0, 5'd5,
         1'b1, 32'h2004, 1'b1);
    // Non-branch select, unknown opcode, then B predicted not taken
    send(32'h400, i16(OP_BEQ, 16'd4, 5'd1, 5'd1), SEL_ALU, 32'd3, 32'd3, 5'd3,
         1'b1, 32'h410, 1'b1);
    send(32'h404, i16(6'h3F, 16'd4, 5'd1, 5'd1), SEL_JB, 32'd3, 32'd3, 5'd3,
         1'b1, 32'h414, 1'b1);
    send(32'h408, i26(OP_B, 26'd100), SEL_JB, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b1);
    idle(3);

    // Stall with a mispredict in S2 and a younger bundle in S1
    ready_i = 1'b0;
    send(32'h500, i16(OP_BNE, 16'd8, 5'd1, 5'd2), SEL_JB, 32'd9, 32'd9, 5'd0,
         1'b1, 32'h520, 1'b0);
    send(32'h504, i16(OP_BEQ, 16'd8, 5'd1, 5'd2), SEL_JB, 32'd9, 32'd9, 5'd0,
         1'b1, 32'h524, 1'b0);
    idle(3);
    ready_i = 1'b1;
    idle(4);

    // Flush together with a new accept and a pending S2 mispredict
    ready_i = 1'b0;
    send(32'h600, i16(OP_BGE, 16'd8, 5'd1, 5'd2), SEL_JB, 32'd1, 32'd2, 5'd0,
         1'b1, 32'h620, 1'b0);
    tick();
    ready_i = 1'b1; flush_i = 1'b1; valid_i = 1'b1;
    pc_i = 32'h700; inst_i = i16(OP_BEQ, 16'd4, 5'd1, 5'd1); alusel_i = SEL_JB;
    tick();
    flush_i = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    check("flush_valid", valid_o, 1'b0);
    check("flush_next_redirect", redirect_o, 1'b0);
    check("flush_ready", ready_o, 1'b1);
    check("flush_counters", {br_total_o, br_miss_o}, {exp_total, exp_miss});
    @(posedge clk); cyc++; #1;

    // Reset in the middle of a stall
    ready_i = 1'b0;
    send(32'h800, i16(OP_BEQ, 16'd4, 5'd1, 5'd1), SEL_JB, 32'd1, 32'd1, 5'd0,
         1'b1, 32'h810, 1'b0);
    send(32'h804, i16(OP_BNE, 16'd4, 5'd1, 5'd1), SEL_JB, 32'd1, 32'd1, 5'd0,
         1'b1, 32'h814, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_stall_valid", valid_o, 1'b0);
    check("rst_stall_ready", ready_o, 1'b1);
    check("rst_stall_counters", {br_total_o, br_miss_o}, 72'd0);
    @(posedge clk); cyc++; #1;
    ready_i = 1'b1;

    // Random traffic with random downstream back-pressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      f = 16'($urandom);
      pc = {$urandom_range(0, 16'hFFFF), 2'b00};
      r1 = vals[$urandom_range(0, 3)];
      send(pc, i16(ops[$urandom_range(0, 8)], f, 5'($urandom), 5'($urandom)),
           ($urandom_range(0, 7) == 0) ? SEL_ALU : SEL_JB, r1, vals[$urandom_range(0, 3)],
           5'($urandom_range(0, 3)), 1'($urandom),
           $urandom_range(0, 1) ? pc + {{14{f[15]}}, f, 2'b00} : $urandom, 1'b0);
    end
    rnd_ready = 1'b0;
    ready_i = 1'b1;
    idle(5);
    check("drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
